// File: rtl/conv_window_gen_if.sv
// Pixel stream in, window stream out, for the convolution front end.
// The master drives the pixel side. The slave, which is the window
// generator, drives the window side.
interface conv_window_gen_if #(
  parameter int SIZE      = 3,
  parameter int WIDTH_BIT = 8
) ();
  logic                                        clear;
  logic                                        pix_valid;
  logic [WIDTH_BIT-1:0]                        pix_in;
  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]    window;
  logic                                        win_valid;
  logic                                        frame_done;

  modport master (
    output clear, pix_valid, pix_in,
    input  window, win_valid, frame_done
  );

  modport slave (
    input  clear, pix_valid, pix_in,
    output window, win_valid, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Raster-to-window generator. SIZE-1 chained line buffers hold the previous
// rows, and a SIZE x SIZE shift register presents the current window.
// win_valid is raised only when the window lies fully inside the image.
module conv_window_gen #(
  parameter int SIZE      = 3,
  parameter int WIDTH_BIT = 8,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8
) (
  input logic             clock,
  input logic             nreset,
  conv_window_gen_if.slave bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(SIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(SIZE - 1);

  logic [CW-1:0]                            col;
  logic [RW-1:0]                            row;
  logic [WIDTH_BIT-1:0]                     lbuf [SIZE-1][IMG_W];
  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] winReg;
  logic                                     winValidReg;
  logic                                     frameDoneReg;
  logic                                     accept;

  // clear takes priority over pix_valid, so a pixel offered together with clear is dropped.
  assign accept = bus.pix_valid && !bus.clear;

  assign bus.window     = winReg;
  assign bus.win_valid  = winValidReg;
  assign bus.frame_done = frameDoneReg;

  // Raster position counters, with the valid and frame-done flags derived from the accepted pixel's position.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      col          <= '0;
      row          <= '0;
      winValidReg  <= 1'b0;
      frameDoneReg <= 1'b0;
    end else if (bus.clear) begin
      col          <= '0;
      row          <= '0;
      winValidReg  <= 1'b0;
      frameDoneReg <= 1'b0;
    end else if (accept) begin
      winValidReg  <= (row >= ROW_FIRST) && (col >= COL_FIRST);
      frameDoneReg <= (row == ROW_LAST) && (col == COL_LAST);
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else begin
      winValidReg  <= 1'b0;
      frameDoneReg <= 1'b0;
    end
  end

  // Chained line buffers. They are deliberately left unreset, because the position counters stop stale data from ever being flagged valid.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int k = 0; k < SIZE - 1; k++) begin
        lbuf[k][0] <= (k == 0) ? bus.pix_in : lbuf[(k == 0) ? 0 : k - 1][IMG_W-1];
        for (int i = 1; i < IMG_W; i++) begin
          lbuf[k][i] <= lbuf[k][i-1];
        end
      end
    end
  end

  // The window shifts left on every accepted pixel. The new right column comes from the line buffers (older rows) and from pix_in (the bottom row).
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      winReg <= '0;
    end else if (accept) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE - 1; j++) begin
          winReg[i][j] <= winReg[i][j+1];
        end
      end
      winReg[SIZE-1][SIZE-1] <= bus.pix_in;
      for (int k = 1; k < SIZE; k++) begin
        winReg[SIZE-1-k][SIZE-1] <= lbuf[k-1][IMG_W-1];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed test bench for conv_window_gen with SIZE=3 on a 5x5 image.
// Pixel values are base + 5*row + col, so every expected window can be
// rebuilt from its top-left value.
module tb_conv_window_gen;

  localparam int SIZE  = 3;
  localparam int WB    = 8;
  localparam int IMG_W = 5;
  localparam int IMG_H = 5;

  typedef struct {
    bit         valid;
    bit         clr;
    logic [7:0] pix;
    bit         expValid;
    bit         expDone;
    logic [7:0] expTopLeft;
  } vec_t;

  logic clock;
  logic nreset;
  int   testsRun;
  int   testsFailed;
  vec_t vecs[$];

  conv_window_gen_if #(.SIZE(SIZE), .WIDTH_BIT(WB)) bus ();

  conv_window_gen #(
    .SIZE(SIZE), .WIDTH_BIT(WB), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clock (clock),
    .nreset(nreset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Adds one whole frame to the vector table. A gapped frame puts an idle cycle after each pixel.
  task automatic addFrame(input int base, input bit gapped);
    vec_t v;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        v.valid      = 1'b1;
        v.clr        = 1'b0;
        v.pix        = 8'(base + 5 * r + c);
        v.expValid   = (r >= SIZE - 1) && (c >= SIZE - 1);
        v.expDone    = (r == IMG_H - 1) && (c == IMG_W - 1);
        v.expTopLeft = 8'(base + 5 * (r - SIZE + 1) + (c - SIZE + 1));
        vecs.push_back(v);
        if (gapped) begin
          v.valid    = 1'b0;
          v.expValid = 1'b0;
          v.expDone  = 1'b0;
          vecs.push_back(v);
        end
      end
    end
  endtask

  // Drives one cycle of inputs at the falling edge, then waits until just after the rising edge.
  task automatic applyStimulus(input bit valid, input bit clr, input logic [7:0] pix);
    @(negedge clock);
    bus.pix_valid = valid;
    bus.clear     = clr;
    bus.pix_in    = pix;
    @(posedge clock);
    #1;
  endtask

  // Compares the flags and, when a window is expected, the whole window against the one built from its top-left value.
  task automatic checkOutput(input string name, input bit expValid, input bit expDone,
                             input logic [7:0] topLeft);
    logic [SIZE-1:0][SIZE-1:0][WB-1:0] expWin;
    testsRun++;
    if (bus.win_valid !== expValid) begin
      testsFailed++;
      $display("[TB] FAIL %s win_valid: got %0b expected %0b", name, bus.win_valid, expValid);
    end
    testsRun++;
    if (bus.frame_done !== expDone) begin
      testsFailed++;
      $display("[TB] FAIL %s frame_done: got %0b expected %0b", name, bus.frame_done, expDone);
    end
    if (expValid) begin
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          expWin[i][j] = topLeft + 8'(5 * i + j);
      testsRun++;
      if (bus.window !== expWin) begin
        testsFailed++;
        $display("[TB] FAIL %s window: got %h expected %h", name, bus.window, expWin);
      end
    end
  endtask

  // Applies a whole frame vector by vector, with base value 0 and no gaps.
  task automatic runPlainFrame(input string tag);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        applyStimulus(1'b1, 1'b0, 8'(5 * r + c));
        checkOutput($sformatf("%s px%0d", tag, 5 * r + c),
                    (r >= 2) && (c >= 2), (r == 4) && (c == 4), 8'(5 * (r - 2) + (c - 2)));
      end
  endtask

  // Compares window, win_valid and frame_done against zero while the design is held in reset.
  task automatic checkZero(input string name);
    testsRun++;
    if (bus.window !== '0 || bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s: got win=%h v=%0b d=%0b expected all zero", name,
               bus.window, bus.win_valid, bus.frame_done);
    end
  endtask

  initial begin
    testsRun      = 0;
    testsFailed   = 0;
    bus.pix_valid = 1'b0;
    bus.clear     = 1'b0;
    bus.pix_in    = '0;
    nreset        = 1'b1;
    #1 nreset     = 1'b0;
    #2;
    checkZero("reset state");
    @(negedge clock);
    nreset = 1'b1;

    // Vector table: a continuous frame, a back-to-back frame with base 100, then a gapped frame.
    addFrame(0, 1'b0);
    addFrame(100, 1'b0);
    addFrame(0, 1'b1);
    foreach (vecs[n]) begin
      applyStimulus(vecs[n].valid, vecs[n].clr, vecs[n].pix);
      checkOutput($sformatf("vec%0d", n), vecs[n].expValid, vecs[n].expDone, vecs[n].expTopLeft);
    end

    // Reset in the middle of a frame, after pixel 13.
    for (int p = 0; p <= 13; p++) begin
      applyStimulus(1'b1, 1'b0, 8'(p));
      checkOutput($sformatf("prereset px%0d", p), (p >= 12), 1'b0, 8'(p - 12));
    end
    @(negedge clock);
    bus.pix_valid = 1'b1;
    bus.pix_in    = 8'd99;
    nreset        = 1'b0;
    #1;
    checkZero("mid reset immediate");
    @(posedge clock);
    #1;
    checkZero("mid reset held");
    @(negedge clock);
    bus.pix_valid = 1'b0;
    nreset        = 1'b1;
    runPlainFrame("after reset");

    // clear arrives together with pixel 8, and that pixel must be dropped.
    for (int p = 0; p < 8; p++) begin
      applyStimulus(1'b1, 1'b0, 8'(p));
      checkOutput($sformatf("preclear px%0d", p), 1'b0, 1'b0, 8'd0);
    end
    applyStimulus(1'b1, 1'b1, 8'd8);
    checkOutput("clear cycle", 1'b0, 1'b0, 8'd0);
    runPlainFrame("after clear");

    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("idle tail", 1'b0, 1'b0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
